// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M-style multiply/divide unit.
// No logic of its own; constants are sized for the widest legal XLEN and sliced by users.
// Backpressure: n/a.
package muldiv_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [MAX_XLEN-1:0] ALL_ONES = '1;
  localparam logic [MAX_XLEN-1:0] MOST_NEG = {1'b1, {(MAX_XLEN-1){1'b0}}};

  function automatic logic is_div_op(input op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and final sign correction / result selection.
// Latency: purely combinational.
// Backpressure: none, follows the latched request registers of the parent.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  op_e               op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [2*XLEN-1:0] raw,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic [XLEN-1:0]   res
);

  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;

    // raw holds the magnitude product, or {remainder, quotient} for divides
    prod = (a_neg ^ b_neg) ? -raw : raw;
    quot = (a_neg ^ b_neg) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    rem  = a_neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];

    res = prod[XLEN-1:0];
    case (op)
      OP_MUL:                      res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             res = quot;
      OP_REM, OP_REMU:             res = rem;
      default:                     res = prod[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit, one bit per cycle; MULDIV_EARLY_OUT_EN short-cuts div-by-zero/overflow.
// Latency: result valid XLEN+1 edges after accept (1 edge for special divides when early-out is built in).
// Backpressure: single outstanding op; result held in DONE until out_ready, in_ready only in IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);
  localparam logic [XLEN-1:0] ONES  = ALL_ONES[XLEN-1:0];
  localparam logic [XLEN-1:0] MNEG  = MOST_NEG[MAX_XLEN-1 -: XLEN];

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   res_fixed;
  logic [2*XLEN-1:0] acc_init;
  logic [2*XLEN-1:0] acc_cur;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic              early_out;
  logic [XLEN-1:0]   special_res;
  logic              accept;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .raw   (acc_q),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .res   (res_fixed)
  );

  // Datapath: first BUSY cycle seeds the accumulator from the latched magnitudes.
  always_comb begin
    acc_init = {{XLEN{1'b0}}, is_div_op(op_q) ? a_mag : b_mag};
    acc_cur  = (cnt_q == '0) ? acc_init : acc_q;
    mul_sum  = {1'b0, acc_cur[2*XLEN-1:XLEN]} + (acc_cur[0] ? {1'b0, a_mag} : '0);
    rem_sh   = {acc_cur[2*XLEN-1:XLEN], acc_cur[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_mag};
    if (is_div_op(op_q)) begin
      acc_step = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_cur[XLEN-2:0], 1'b0}
                                : {rem_diff[XLEN-1:0], acc_cur[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_cur[XLEN-1:1]};
    end

    div_zero = is_div_op(op_q) && (b_q == '0);
    div_ovf  = is_div_op(op_q) && !op_q[0] && (a_q == MNEG) && (b_q == ONES);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = op_q[1] ? a_q : ONES;
    end else begin
      special_res = op_q[1] ? '0 : a_q;
    end
`ifdef MULDIV_EARLY_OUT_EN
    early_out = special;
`else
    early_out = 1'b0;
`endif
  end

  assign accept = in_valid && (state_q == ST_IDLE) && !flush;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (early_out) begin
          state_d  = ST_DONE;
          result_d = special_res;
          cnt_d    = '0;
        end else if (cnt_q == LAST) begin
          state_d  = ST_DONE;
          result_d = special ? special_res : res_fixed;
          cnt_d    = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32: results, latency, hold, flush and async reset.
// Build with MULDIV_EARLY_OUT_EN defined to expect 1-cycle special-case latency.
module tb_muldiv_unit;

  localparam int NORM_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request, scrambles the inputs after acceptance, waits for out_valid.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] ra, input logic [31:0] rb,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    op       = f3;
    a        = ra;
    b        = rb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = ~f3;
    a        = ~ra;
    b        = ~rb;
    lat      = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic watch_no_valid(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;

    vecs[0]  = '{"mul_7_m3",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT};
    vecs[1]  = '{"mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT};
    vecs[2]  = '{"mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NORM_LAT};
    vecs[3]  = '{"mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORM_LAT};
    vecs[4]  = '{"mulh_mneg_sq",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORM_LAT};
    vecs[5]  = '{"div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, NORM_LAT};
    vecs[6]  = '{"rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, NORM_LAT};
    vecs[7]  = '{"divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,        NORM_LAT};
    vecs[8]  = '{"remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,         NORM_LAT};
    vecs[9]  = '{"div_20_m6",     3'b100, 32'd20,       32'hFFFF_FFFA, 32'hFFFF_FFFD, NORM_LAT};
    vecs[10] = '{"rem_20_m6",     3'b110, 32'd20,       32'hFFFF_FFFA, 32'd2,         NORM_LAT};
    vecs[11] = '{"divu_10_0",     3'b101, 32'd10,       32'd0,        32'hFFFF_FFFF, SPEC_LAT};
    vecs[12] = '{"remu_10_0",     3'b111, 32'd10,       32'd0,        32'd10,        SPEC_LAT};
    vecs[13] = '{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT};
    vecs[14] = '{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPEC_LAT};
    vecs[15] = '{"rem_m7_0",      3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, SPEC_LAT};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'b000;
    a         = '0;
    b         = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].va, vecs[i].vb, res, lat);
      check({vecs[i].name, "_res"}, 64'(res), 64'(vecs[i].exp));
      check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      handshake();
    end

    // Result held while consumer stalls
    run_op(3'b000, 32'd5, 32'd6, res, lat);
    check("hold_first", 64'(res), 64'd30);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'd30);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    handshake();
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);

    // Flush in BUSY cycle 10
    @(negedge clk);
    op       = 3'b000;
    a        = 32'd9;
    b        = 32'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    watch_no_valid("flush_no_valid", 40);

    // Flush wins over in_valid in IDLE
    @(negedge clk);
    op       = 3'b000;
    a        = 32'd2;
    b        = 32'd2;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("idle_flush_not_accepted", 64'(in_ready), 64'd1);
    watch_no_valid("idle_flush_no_valid", 40);

    // Async reset mid-BUSY
    @(negedge clk);
    op       = 3'b000;
    a        = 32'd11;
    b        = 32'd13;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_valid("arst_no_valid", 40);
    run_op(3'b000, 32'd3, 32'd4, res, lat);
    check("post_rst_mul_res", 64'(res), 64'd12);
    check("post_rst_mul_lat", 64'(lat), 64'(NORM_LAT));
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  in  1  request present.
REQ-005 SHALL have port: in_ready  out  1  unit can accept a request.
REQ-006 SHALL have port: op  in  3  operation, RV32M funct3 encoding.
REQ-007 SHALL have port: a  in  XLEN  rs1 operand.
REQ-008 SHALL have port: b  in  XLEN  rs2 operand.
REQ-009 SHALL have port: flush  in  1  synchronous abort of the in-flight operation.
REQ-010 SHALL have port: out_valid  out  1  result available.
REQ-011 SHALL have port: out_ready  in  1  consumer takes result.
REQ-012 SHALL have port: result  out  XLEN  registered result.

Function
REQ-013 SHALL decode op as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept on in_valid & in_ready & !flush, latching op, a and b.
REQ-016 SHALL process one bit per cycle in BUSY using a shift-add multiplier or a restoring divider on operand magnitudes, counting XLEN iterations.
REQ-017 SHALL fix signs in post-processing: MUL/MULH/DIV/REM signed; MULHSU treats a as signed and b as unsigned; U variants unsigned.
REQ-018 SHALL return the low XLEN bits of the 2*XLEN product for MUL and the high XLEN bits for MULH/MULHSU/MULHU.
REQ-019 SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-020 SHALL handle divide-by-zero as: DIV/DIVU result all-ones; REM/REMU result = a.
REQ-021 SHALL handle signed overflow (a = most-negative, b = -1) as: DIV result = a; REM result = 0.
REQ-022 SHALL raise out_valid on the (XLEN+1)th rising edge after the accepting edge (normal path).
REQ-023 SHALL hold out_valid and result stable in DONE until out_valid & out_ready, then return to IDLE on that edge.
REQ-024 SHALL NOT accept a new request in the same cycle as the result handshake; in_ready rises the cycle after.
REQ-025 SHALL, on flush in BUSY or DONE, return to IDLE on the next edge with out_valid=0 and discard the result.
REQ-026 SHALL give flush priority over in_valid in IDLE; no request is accepted that cycle.
REQ-027 SHALL ignore op, a and b changes after acceptance.

Reset
REQ-028 SHALL on rst_n=0 immediately force IDLE, in_ready=1, out_valid=0, result=0, and clear the iteration counter and internal accumulators.
REQ-029 SHALL abandon any operation on reset mid-operation; no out_valid may follow release of rst_n.

Configuration
REQ-030 SHALL, when macro MULDIV_EARLY_OUT_EN is defined, send divide-by-zero and signed-overflow cases directly to DONE, with out_valid on the 1st edge after accept.
REQ-031 SHALL, without MULDIV_EARLY_OUT_EN, give these cases the normal XLEN+1 latency while returning the same results as REQ-020 and REQ-021.

Structure
REQ-032 SHALL place the op encoding enum, FSM state enum and the special-result constants (all-ones, most-negative) in shared package muldiv_pkg.
REQ-033 SHALL isolate operand magnitude extraction and result negation in combinational sub-module muldiv_sign_fix; the iteration datapath and FSM SHALL remain in muldiv_unit.

Verification (XLEN=32)
REQ-034 SHALL cover: MUL a=7, b=-3 -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 SHALL cover: DIVU 10/0 -> 0xFFFFFFFF and REMU 10/0 -> 10; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0; latency 1 cycle with MULDIV_EARLY_OUT_EN, 33 cycles without.
REQ-037 SHALL cover: out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready=0; in_ready=1 the cycle after the handshake.
REQ-038 SHALL cover: flush at BUSY cycle 10 -> IDLE next edge, no out_valid; flush together with in_valid in IDLE -> request not accepted.
REQ-039 SHALL cover: rst_n pulsed low mid-BUSY -> outputs reset immediately (asynchronously); a subsequent MUL 3x4 -> 12 completes normally.
